// File: rtl/pipe_if_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC selector codes,
// IF state encoding and default fetch addresses.
package pipe_if_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] EXC_PC_DEF   = 32'h0040_0004;

   localparam logic [2:0] NPC_SEQ = 3'd0;
   localparam logic [2:0] NPC_BR  = 3'd1;
   localparam logic [2:0] NPC_J   = 3'd2;
   localparam logic [2:0] NPC_JR  = 3'd3;
   localparam logic [2:0] NPC_EXC = 3'd4;

   typedef enum logic [1:0] {
      IF_RESET = 2'd0,
      IF_REQ   = 2'd1,
      IF_HOLD  = 2'd2
   } if_state_t;

   // Selector codes 5..7 behave like NPC_SEQ and never redirect.
   function automatic logic is_redirect_sel(input logic [2:0] sel);
      return (sel == NPC_BR) || (sel == NPC_J) || (sel == NPC_JR) || (sel == NPC_EXC);
   endfunction

endpackage

// File: rtl/pipe_if_npc_calc.sv
// Combinational redirect-target computation for the instruction in ID
// (branch, j/jal, jr/jalr, exception vector).
module pipe_if_npc_calc
   import pipe_if_pkg::*;
#(
   parameter logic [31:0] EXC_PC = EXC_PC_DEF
) (
   input  logic [31:0] id_pc,
   input  logic [15:0] id_imm,
   input  logic [25:0] id_j_imm,
   input  logic [31:0] id_rs,
   input  logic [2:0]  npc_mux_sel,
   output logic        redirect,
   output logic [31:0] target
);

   logic [31:0] pc_plus4;
   logic [31:0] br_offset;

   assign pc_plus4  = id_pc + 32'd4;
   assign br_offset = {{14{id_imm[15]}}, id_imm, 2'b00};
   assign redirect  = is_redirect_sel(npc_mux_sel);

   // NOTE: target gets a default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      target = pc_plus4;
      case (npc_mux_sel)
         NPC_BR:  target = pc_plus4 + br_offset;
         NPC_J:   target = {pc_plus4[31:28], id_j_imm, 2'b00};
         NPC_JR:  target = id_rs & 32'hFFFF_FFFC;
         NPC_EXC: target = EXC_PC;
         default: target = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// holds the fetched word for ID and applies delay-slot redirects from ID.
module pipe_if
   import pipe_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_allowin,
   input  logic        id_redirect_valid,
   input  logic [2:0]  npc_mux_sel,
   input  logic [31:0] id_pc,
   input  logic [15:0] id_imm,
   input  logic [25:0] id_j_imm,
   input  logic [31:0] id_rs,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_id_validto,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out
);

   if_state_t   state;
   if_state_t   state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] redirect_pc;
   logic        redirect_pending;
   logic        sel_redirect;
   logic [31:0] redirect_target;
   logic        redirect_take;
   logic        capture;
   logic        handoff;
   logic [31:0] next_pc;

   pipe_if_npc_calc #(
      .EXC_PC (EXC_PC)
   ) u_npc_calc (
      .id_pc       (id_pc),
      .id_imm      (id_imm),
      .id_j_imm    (id_j_imm),
      .id_rs       (id_rs),
      .npc_mux_sel (npc_mux_sel),
      .redirect    (sel_redirect),
      .target      (redirect_target)
   );

   assign redirect_take = id_redirect_valid & sel_redirect;
   assign capture       = (state == IF_REQ) & imem_ready;
   assign handoff       = (state == IF_HOLD) & id_allowin;
   assign imem_addr     = fetch_pc;

   // Handshake outputs decode only the registered state, so imem never reaches ID combinationally.
   always_comb begin
      state_nxt     = state;
      imem_req      = 1'b0;
      if_id_validto = 1'b0;
      case (state)
         IF_RESET: state_nxt = IF_REQ;
         IF_REQ: begin
            imem_req = 1'b1;
            if (imem_ready) state_nxt = IF_HOLD;
         end
         IF_HOLD: begin
            if_id_validto = 1'b1;
            if (id_allowin) state_nxt = IF_REQ;
         end
         default: state_nxt = IF_RESET;
      endcase
   end

   // A redirect arriving on the handoff edge bypasses the pending register.
   always_comb begin
      next_pc = pc_out + 32'd4;
      if (redirect_take) begin
         next_pc = redirect_target;
      end else if (redirect_pending) begin
         next_pc = redirect_pc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IF_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc         <= RESET_PC;
         pc_out           <= 32'd0;
         instr_out        <= 32'd0;
         redirect_pending <= 1'b0;
         redirect_pc      <= 32'd0;
      end else begin
         if (capture) begin
            pc_out    <= fetch_pc;
            instr_out <= imem_rdata;
         end
         if (handoff) begin
            fetch_pc         <= next_pc;
            redirect_pending <= 1'b0;
         end else if (redirect_take) begin
            redirect_pc      <= redirect_target;
            redirect_pending <= 1'b1;
         end
      end
   end

endmodule
